bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus owner selection with lock/hold limiting.
// Outputs are fully registered; a request sampled at one edge is granted
// at the next edge. Optional macro BUS_ARB_PRIORITY_EN adds a prio_mask
// input whose requests win over (and preempt) non-priority owners.
// fsm_state exposes the IDLE(0)/OWNED(1) state for observation.
//
// Handshake: req[i] is a level request; source i may drive the bus in any
// cycle where bus_valid=1 and grant[i]=1 (selectSignal==i). lock only has
// effect while the owner keeps its req asserted.
module bus_arbiter #(
    parameter int NUM_SRC  = 24,
    parameter int MAX_HOLD = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] req,
    input  logic               lock,
`ifdef BUS_ARB_PRIORITY_EN
    input  logic [NUM_SRC-1:0] prio_mask,
`endif
    output logic [NUM_SRC-1:0] grant,
    output logic [4:0]         selectSignal,
    output logic               bus_valid,
    output logic [3:0]         hold_cnt,
    output logic               fsm_state
);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t             state, state_nx;
    logic [4:0]         last_owner, last_owner_nx;
    logic [NUM_SRC-1:0] grant_nx;
    logic [4:0]         sel_nx;
    logic               valid_nx;
    logic [3:0]         hold_nx;

    logic               rr_found;
    logic [4:0]         rr_pick;
    logic               prio_found;
    logic [4:0]         prio_pick;
    logic               owner_req;
    logic               others;
    logic               keep;
    logic               preempt;

    assign fsm_state = state;
    assign owner_req = |(req & grant);
    assign others    = |(req & ~grant);

    // Round-robin search starting just after the last owner, wrapping at NUM_SRC.
    // The current owner naturally comes last, so it only wins when alone.
    always_comb begin
        int         idx;
        logic [4:0] idx5;
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = 0;
        idx5     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(last_owner) + 1 + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx5 = 5'(idx);
            if (!rr_found && req[idx5]) begin
                rr_found = 1'b1;
                rr_pick  = idx5;
            end
        end
    end

    // Lowest-index priority request, and whether it must displace the owner.
    always_comb begin
        prio_found = 1'b0;
        prio_pick  = '0;
        preempt    = 1'b0;
`ifdef BUS_ARB_PRIORITY_EN
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i] && prio_mask[i]) begin
                prio_found = 1'b1;
                prio_pick  = 5'(i);
            end
        end
        // A keeping owner that itself has priority is not displaced.
        preempt = prio_found && !(keep && |(grant & prio_mask));
`endif
    end

    // Next-state and next-output decode; defaults hold current values.
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        sel_nx        = selectSignal;
        valid_nx      = bus_valid;
        hold_nx       = hold_cnt;
        last_owner_nx = last_owner;
        keep = (state == OWNED) && lock && owner_req &&
               ((int'(hold_cnt) < MAX_HOLD - 1) || !others);
        if (preempt) begin
            state_nx            = OWNED;
            grant_nx            = '0;
            grant_nx[prio_pick] = 1'b1;
            sel_nx              = prio_pick;
            valid_nx            = 1'b1;
            hold_nx             = '0;
            last_owner_nx       = prio_pick;
        end else if (keep) begin
            hold_nx = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
        end else if (rr_found) begin
            state_nx          = OWNED;
            grant_nx          = '0;
            grant_nx[rr_pick] = 1'b1;
            sel_nx            = rr_pick;
            valid_nx          = 1'b1;
            hold_nx           = '0;
            last_owner_nx     = rr_pick;
        end else begin
            state_nx = IDLE;
            grant_nx = '0;
            sel_nx   = '0;
            valid_nx = 1'b0;
            hold_nx  = '0;
        end
    end

    // State and output registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= IDLE;
            grant        <= '0;
            selectSignal <= '0;
            bus_valid    <= 1'b0;
            hold_cnt     <= '0;
            last_owner   <= 5'(NUM_SRC - 1);
        end else begin
            state        <= state_nx;
            grant        <= grant_nx;
            selectSignal <= sel_nx;
            bus_valid    <= valid_nx;
            hold_cnt     <= hold_nx;
            last_owner   <= last_owner_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (default NUM_SRC=24, MAX_HOLD=8).
module tb_bus_arbiter;

    localparam int N = 24;

    logic         clock;
    logic         clear;
    logic [N-1:0] req;
    logic         lock;
    logic [N-1:0] prio_mask;
    logic [N-1:0] grant;
    logic [4:0]   selectSignal;
    logic         bus_valid;
    logic [3:0]   hold_cnt;
    logic         fsm_state;

    int tests;
    int fails;

    bus_arbiter #(.NUM_SRC(N), .MAX_HOLD(8)) dut (
        .clock        (clock),
        .clear        (clear),
        .req          (req),
        .lock         (lock),
`ifdef BUS_ARB_PRIORITY_EN
        .prio_mask    (prio_mask),
`endif
        .grant        (grant),
        .selectSignal (selectSignal),
        .bus_valid    (bus_valid),
        .hold_cnt     (hold_cnt),
        .fsm_state    (fsm_state)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance one rising edge, then settle away from the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // expect a single owner idx with given hold count
    task automatic chk_own(input string tag, input int idx, input int hold);
        logic [N-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".sel"}, 32'(selectSignal), 32'(idx));
        chk({tag, ".valid"}, 32'(bus_valid), 32'd1);
        chk({tag, ".hold"}, 32'(hold_cnt), 32'(hold));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".sel"}, 32'(selectSignal), 32'd0);
        chk({tag, ".valid"}, 32'(bus_valid), 32'd0);
        chk({tag, ".hold"}, 32'(hold_cnt), 32'd0);
        chk({tag, ".state"}, 32'(fsm_state), 32'd0);
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        tests     = 0;
        fails     = 0;
        clear     = 1'b1;
        req       = '0;
        lock      = 1'b0;
        prio_mask = '0;
        tick();
        tick();
        chk_idle("reset");
        clear = 1'b0;

        // single PC request, then release
        req = bit_of(20);
        tick();
        chk_own("pc_grant", 20, 0);
        chk("pc_state", 32'(fsm_state), 32'd1);
        req = '0;
        tick();
        chk_idle("pc_release");

        // round robin across 3, 17, 21 from a fresh clear
        clear = 1'b1;
        req   = bit_of(3) | bit_of(17) | bit_of(21);
        tick();
        chk_idle("clear_overrides_req");
        clear = 1'b0;
        tick(); chk_own("rr0", 3, 0);
        tick(); chk_own("rr1", 17, 0);
        tick(); chk_own("rr2", 21, 0);
        tick(); chk_own("rr3", 3, 0);
        tick(); chk_own("rr4", 17, 0);
        tick(); chk_own("rr5", 21, 0);

        // wrap from 23 to 0
        req = bit_of(23);
        tick(); chk_own("own23", 23, 0);
        req = bit_of(0) | bit_of(22);
        tick(); chk_own("wrap0", 0, 0);

        // locked hold limited to MAX_HOLD when others wait
        req = bit_of(5);
        tick(); chk_own("own5", 5, 0);
        lock = 1'b1;
        req  = bit_of(5) | bit_of(9);
        for (int i = 1; i <= 7; i++) begin
            tick(); chk_own($sformatf("hold5_%0d", i), 5, i);
        end
        tick(); chk_own("handoff9", 9, 0);

        // lone locked owner keeps the bus, hold_cnt saturates
        req = bit_of(5);
        tick(); chk_own("reown5", 5, 0);
        for (int i = 1; i <= 20; i++) begin
            tick(); chk_own($sformatf("sat_%0d", i), 5, (i > 15) ? 15 : i);
        end

        // owner dropping req releases despite lock
        req = bit_of(9);
        tick(); chk_own("drop_to9", 9, 0);
        req = '0;
        tick(); chk_idle("drop_idle");

        // clear during locked hold
        req = bit_of(7);
        tick(); chk_own("own7", 7, 0);
        tick(); tick(); tick(); tick();
        chk_own("hold7_4", 7, 4);
        clear = 1'b1;
        tick(); chk_idle("clear_mid_hold");
        clear = 1'b0;
        lock  = 1'b0;
        req   = bit_of(0) | bit_of(4);
        tick(); chk_own("after_clear0", 0, 0);

        // locked owner 2 with a competing request at 21
        req = bit_of(2);
        tick(); chk_own("own2", 2, 0);
        lock = 1'b1;
        req  = bit_of(2) | bit_of(21);
`ifdef BUS_ARB_PRIORITY_EN
        prio_mask = bit_of(21);
        tick(); chk_own("prio21", 21, 0);
`else
        for (int i = 1; i <= 7; i++) begin
            tick(); chk_own($sformatf("hold2_%0d", i), 2, i);
        end
        tick(); chk_own("expire21", 21, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
